// File: rtl/ra_builder.sv
// Region-array builder: walks the tile grid and writes one CTRL word plus the per-list
// object pointer words for every tile. Optional build macro: RA_ZCLEAR_DIS_EN (adds ra_zclear_dis input).
//
// state | meaning
// IDLE  | waiting for ra_gen_trig; configuration latched when it arrives
// CTRL  | presenting the tile control word
// PTR   | presenting pointer words that are not the last one of the tile
// NEXT  | presenting the last pointer word; its acceptance steps to the next tile or to DONE
// DONE  | one-cycle completion pulse
module ra_builder (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ra_gen_trig,
   input  logic [31:0] FPU_PARAM_CFG,
   input  logic [31:0] REGION_BASE,
   input  logic [23:0] OL_BASE,
   input  logic [9:0]  OPB_BYTES,
   input  logic [4:0]  LIST_EN,
   input  logic [5:0]  TILE_X_MAX,
   input  logic [5:0]  TILE_Y_MAX,
`ifdef RA_ZCLEAR_DIS_EN
   input  logic        ra_zclear_dis,
`endif
   input  logic        ra_vram_wait,
   output logic        ra_vram_wr,
   output logic [23:0] ra_vram_addr,
   output logic [31:0] ra_vram_dout,
   output logic        ra_busy,
   output logic        ra_done
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CTRL = 3'd1,
      PTR  = 3'd2,
      NEXT = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] addr_q, addr_d;
   logic [23:0] acc_q, acc_d;
   logic [2:0]  list_q, list_d;
   logic [5:0]  tile_x_q, tile_x_d;
   logic [5:0]  tile_y_q, tile_y_d;
   logic [5:0]  x_max_q, x_max_d;
   logic [5:0]  y_max_q, y_max_d;
   logic [9:0]  opb_q, opb_d;
   logic [4:0]  list_en_q, list_en_d;
   logic        v2_q, v2_d;
   logic        zclr_q, zclr_d;

   logic        zclr_in;
   logic        wr;
   logic [31:0] dout;
   logic        accept;
   logic        last_tile;
   logic        list_on;
   logic [2:0]  last_list;
   logic [31:0] ctrl_word;
   logic [31:0] ptr_word;
   logic        unused_cfg;

`ifdef RA_ZCLEAR_DIS_EN
   assign zclr_in = ra_zclear_dis;
`else
   assign zclr_in = 1'b0;
`endif

   assign unused_cfg = ^{FPU_PARAM_CFG[31:22], FPU_PARAM_CFG[20:0], REGION_BASE[31:24]};

   always_comb begin
      case (list_q)
         3'd0:    list_on = list_en_q[0];
         3'd1:    list_on = list_en_q[1];
         3'd2:    list_on = list_en_q[2];
         3'd3:    list_on = list_en_q[3];
         3'd4:    list_on = list_en_q[4];
         default: list_on = 1'b0;
      endcase
   end

   assign last_tile = (tile_x_q == x_max_q) && (tile_y_q == y_max_q);
   assign last_list = v2_q ? 3'd4 : 3'd3;
   assign ctrl_word = {last_tile, zclr_q, 16'd0, tile_y_q, tile_x_q, 2'b00};
   assign ptr_word  = list_on ? {8'h00, acc_q} : 32'h8000_0000;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      acc_d     = acc_q;
      list_d    = list_q;
      tile_x_d  = tile_x_q;
      tile_y_d  = tile_y_q;
      x_max_d   = x_max_q;
      y_max_d   = y_max_q;
      opb_d     = opb_q;
      list_en_d = list_en_q;
      v2_d      = v2_q;
      zclr_d    = zclr_q;
      wr        = 1'b0;
      dout      = 32'd0;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            if (ra_gen_trig) begin
               addr_d    = REGION_BASE[23:0];
               acc_d     = OL_BASE;
               list_d    = 3'd0;
               tile_x_d  = 6'd0;
               tile_y_d  = 6'd0;
               x_max_d   = TILE_X_MAX;
               y_max_d   = TILE_Y_MAX;
               opb_d     = OPB_BYTES;
               list_en_d = LIST_EN;
               v2_d      = FPU_PARAM_CFG[21];
               zclr_d    = zclr_in;
               state_d   = CTRL;
            end
         end
         CTRL: begin
            wr     = 1'b1;
            dout   = ctrl_word;
            accept = ~ra_vram_wait;
            if (accept) begin
               addr_d  = addr_q + 24'd4;
               list_d  = 3'd0;
               state_d = PTR;
            end
         end
         PTR: begin
            wr     = 1'b1;
            dout   = ptr_word;
            accept = ~ra_vram_wait;
            if (accept) begin
               addr_d = addr_q + 24'd4;
               acc_d  = acc_q + {14'd0, opb_q};
               list_d = list_q + 3'd1;
               if (list_q + 3'd1 == last_list) begin
                  state_d = NEXT;
               end
            end
         end
         NEXT: begin
            wr     = 1'b1;
            dout   = ptr_word;
            accept = ~ra_vram_wait;
            if (accept) begin
               addr_d = addr_q + 24'd4;
               // v1 tiles never write the puncht slot but still reserve it
               acc_d  = v2_q ? acc_q + {14'd0, opb_q} : acc_q + {13'd0, opb_q, 1'b0};
               list_d = 3'd0;
               if (last_tile) begin
                  state_d = DONE;
               end else begin
                  state_d = CTRL;
                  if (tile_x_q == x_max_q) begin
                     tile_x_d = 6'd0;
                     tile_y_d = tile_y_q + 6'd1;
                  end else begin
                     tile_x_d = tile_x_q + 6'd1;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= 24'd0;
         acc_q     <= 24'd0;
         list_q    <= 3'd0;
         tile_x_q  <= 6'd0;
         tile_y_q  <= 6'd0;
         x_max_q   <= 6'd0;
         y_max_q   <= 6'd0;
         opb_q     <= 10'd0;
         list_en_q <= 5'd0;
         v2_q      <= 1'b0;
         zclr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         acc_q     <= acc_d;
         list_q    <= list_d;
         tile_x_q  <= tile_x_d;
         tile_y_q  <= tile_y_d;
         x_max_q   <= x_max_d;
         y_max_q   <= y_max_d;
         opb_q     <= opb_d;
         list_en_q <= list_en_d;
         v2_q      <= v2_d;
         zclr_q    <= zclr_d;
      end
   end

   assign ra_vram_wr   = wr;
   assign ra_vram_addr = addr_q;
   assign ra_vram_dout = dout;
   assign ra_busy      = (state_q == CTRL) || (state_q == PTR) || (state_q == NEXT);
   assign ra_done      = (state_q == DONE);

endmodule

// File: tb/tb_ra_builder.sv
// Scoreboard bench for ra_builder: stimulus pushes expected (addr, data) pairs,
// a negedge monitor pops and compares each presented write.
module tb_ra_builder;

   logic        clock;
   logic        reset_n;
   logic        ra_gen_trig;
   logic [31:0] FPU_PARAM_CFG;
   logic [31:0] REGION_BASE;
   logic [23:0] OL_BASE;
   logic [9:0]  OPB_BYTES;
   logic [4:0]  LIST_EN;
   logic [5:0]  TILE_X_MAX;
   logic [5:0]  TILE_Y_MAX;
   logic        zclr;
   logic        ra_vram_wait;
   logic        ra_vram_wr;
   logic [23:0] ra_vram_addr;
   logic [31:0] ra_vram_dout;
   logic        ra_busy;
   logic        ra_done;

   typedef struct packed {
      logic [23:0] a;
      logic [31:0] d;
   } exp_t;

   exp_t exp_q[$];
   int   vectors;
   int   miscompares;
   int   done_cnt;
   int   wr_cnt;

   ra_builder dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .ra_gen_trig   (ra_gen_trig),
      .FPU_PARAM_CFG (FPU_PARAM_CFG),
      .REGION_BASE   (REGION_BASE),
      .OL_BASE       (OL_BASE),
      .OPB_BYTES     (OPB_BYTES),
      .LIST_EN       (LIST_EN),
      .TILE_X_MAX    (TILE_X_MAX),
      .TILE_Y_MAX    (TILE_Y_MAX),
`ifdef RA_ZCLEAR_DIS_EN
      .ra_zclear_dis (zclr),
`endif
      .ra_vram_wait  (ra_vram_wait),
      .ra_vram_wr    (ra_vram_wr),
      .ra_vram_addr  (ra_vram_addr),
      .ra_vram_dout  (ra_vram_dout),
      .ra_busy       (ra_busy),
      .ra_done       (ra_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (ra_done) done_cnt++;
      if (ra_vram_wr) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write addr=%h data=%h (no write expected)", ra_vram_addr, ra_vram_dout);
         end else begin
            if (ra_vram_addr !== exp_q[0].a || ra_vram_dout !== exp_q[0].d) begin
               miscompares++;
               $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                        ra_vram_addr, ra_vram_dout, exp_q[0].a, exp_q[0].d);
            end
            if (!ra_vram_wait) begin
               void'(exp_q.pop_front());
               wr_cnt++;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push(input logic [23:0] a, input logic [31:0] d);
      exp_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // Returns one cycle after the trigger edge, with the first word on the bus.
   task automatic start(input logic [31:0] fpu, input logic [31:0] region, input logic [23:0] olb,
                        input logic [9:0] opb, input logic [4:0] en, input logic [5:0] xm,
                        input logic [5:0] ym, input logic zc);
      @(posedge clock); #1;
      FPU_PARAM_CFG = fpu;
      REGION_BASE   = region;
      OL_BASE       = olb;
      OPB_BYTES     = opb;
      LIST_EN       = en;
      TILE_X_MAX    = xm;
      TILE_Y_MAX    = ym;
      zclr          = zc;
      ra_gen_trig   = 1'b1;
      @(posedge clock); #1;
      ra_gen_trig   = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (!ra_done && n < budget) begin
         @(posedge clock); #1;
         n++;
      end
      vectors++;
      if (!ra_done) begin
         miscompares++;
         $display("FAIL done_timeout got=0 expected=1 after %0d cycles", budget);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      int          d0;
      int          w0;
      logic [23:0] a;
      int unsigned t;
      logic [31:0] ctrl;
      logic [31:0] ptr;
      logic [4:0]  en;

      vectors = 0; miscompares = 0; done_cnt = 0; wr_cnt = 0;
      reset_n = 1'b0; ra_gen_trig = 1'b0; ra_vram_wait = 1'b0; zclr = 1'b0;
      FPU_PARAM_CFG = '0; REGION_BASE = '0; OL_BASE = '0; OPB_BYTES = '0;
      LIST_EN = '0; TILE_X_MAX = '0; TILE_Y_MAX = '0;
      idle_cycles(3);
      chk("reset_wr",   {31'd0, ra_vram_wr}, 32'd0);
      chk("reset_busy", {31'd0, ra_busy},    32'd0);
      chk("reset_done", {31'd0, ra_done},    32'd0);
      chk("reset_addr", {8'd0, ra_vram_addr}, 32'd0);
      chk("reset_dout", ra_vram_dout,        32'd0);
      reset_n = 1'b1;
      idle_cycles(2);

      // v1, two tiles in X, only opaque enabled
      push(24'h001000, 32'h00000000); push(24'h001004, 32'h00002000);
      push(24'h001008, 32'h80000000); push(24'h00100C, 32'h80000000);
      push(24'h001010, 32'h80000000); push(24'h001014, 32'h80000004);
      push(24'h001018, 32'h00002140); push(24'h00101C, 32'h80000000);
      push(24'h001020, 32'h80000000); push(24'h001024, 32'h80000000);
      d0 = done_cnt;
      start(32'h0, 32'h00001000, 24'h002000, 10'h040, 5'b00001, 6'd0 + 6'd1, 6'd0, 1'b0);
      chk("busy_after_trig", {31'd0, ra_busy}, 32'd1);
      wait_done(100);
      chk("done_busy_low", {31'd0, ra_busy}, 32'd0);
      idle_cycles(5);
      chk("v1_done_pulses", done_cnt - d0, 32'd1);
      chk("v1_queue_drained", exp_q.size(), 32'd0);

      // v2, single tile, all lists enabled
      push(24'h003000, 32'h80000000); push(24'h003004, 32'h00002000);
      push(24'h003008, 32'h00002040); push(24'h00300C, 32'h00002080);
      push(24'h003010, 32'h000020C0); push(24'h003014, 32'h00002100);
      start(32'h00200000, 32'h00003000, 24'h002000, 10'h040, 5'b11111, 6'd0, 6'd0, 1'b0);
      wait_done(100);
      idle_cycles(3);
      chk("v2_queue_drained", exp_q.size(), 32'd0);

      // back-pressure for 3 cycles on the second word
      push(24'h001000, 32'h00000000); push(24'h001004, 32'h00002000);
      push(24'h001008, 32'h80000000); push(24'h00100C, 32'h80000000);
      push(24'h001010, 32'h80000000); push(24'h001014, 32'h80000004);
      push(24'h001018, 32'h00002140); push(24'h00101C, 32'h80000000);
      push(24'h001020, 32'h80000000); push(24'h001024, 32'h80000000);
      w0 = wr_cnt;
      start(32'h0, 32'h00001000, 24'h002000, 10'h040, 5'b00001, 6'd1, 6'd0, 1'b0);
      @(posedge clock); #1;
      ra_vram_wait = 1'b1;
      idle_cycles(3);
      ra_vram_wait = 1'b0;
      wait_done(100);
      idle_cycles(3);
      chk("wait_write_count", wr_cnt - w0, 32'd10);
      chk("wait_queue_drained", exp_q.size(), 32'd0);

      // reset during the 4th write
      push(24'h001000, 32'h00000000); push(24'h001004, 32'h00002000);
      push(24'h001008, 32'h80000000);
      w0 = wr_cnt;
      start(32'h0, 32'h00001000, 24'h002000, 10'h040, 5'b00001, 6'd1, 6'd0, 1'b0);
      idle_cycles(3);
      reset_n = 1'b0;
      #1;
      chk("rst_mid_wr",   {31'd0, ra_vram_wr}, 32'd0);
      chk("rst_mid_busy", {31'd0, ra_busy},    32'd0);
      chk("rst_mid_addr", {8'd0, ra_vram_addr}, 32'd0);
      idle_cycles(3);
      reset_n = 1'b1;
      idle_cycles(20);
      chk("rst_write_count", wr_cnt - w0, 32'd3);
      chk("rst_no_resume_wr", {31'd0, ra_vram_wr}, 32'd0);

      // full 64x64 grid, v1, with address and pointer wrap
      a  = 24'hFFFF00;
      en = 5'b10101;
      for (int y = 0; y < 64; y++) begin
         for (int x = 0; x < 64; x++) begin
            t    = 32'(y * 64 + x);
            ctrl = ((y == 63 && x == 63) ? 32'h80000000 : 32'h0) | (32'(y) << 8) | (32'(x) << 2);
            push(a, ctrl);
            a = a + 24'd4;
            for (int l = 0; l < 4; l++) begin
               ptr = (32'h00FFF000 + (t * 5 + 32'(l)) * 32'd1023) & 32'h00FFFFFF;
               push(a, en[l] ? ptr : 32'h80000000);
               a = a + 24'd4;
            end
         end
      end
      w0 = wr_cnt;
      d0 = done_cnt;
      start(32'hFFDFFFFF, 32'hABFFFF00, 24'hFFF000, 10'd1023, en, 6'd63, 6'd63, 1'b0);
      idle_cycles(100);
      ra_gen_trig = 1'b1;
      @(posedge clock); #1;
      ra_gen_trig = 1'b0;
      wait_done(25000);
      // trigger during DONE must be ignored as well
      ra_gen_trig = 1'b1;
      @(posedge clock); #1;
      ra_gen_trig = 1'b0;
      idle_cycles(20);
      chk("grid_write_count", wr_cnt - w0, 32'd20480);
      chk("grid_done_pulses", done_cnt - d0, 32'd1);
      chk("grid_queue_drained", exp_q.size(), 32'd0);

`ifdef RA_ZCLEAR_DIS_EN
      push(24'h004000, 32'hC0000000); push(24'h004004, 32'h80000000);
      push(24'h004008, 32'h80000000); push(24'h00400C, 32'h80000000);
      push(24'h004010, 32'h80000000);
      start(32'h0, 32'h00004000, 24'h002000, 10'h040, 5'b00000, 6'd0, 6'd0, 1'b1);
      wait_done(100);
      idle_cycles(3);
      chk("zclr_queue_drained", exp_q.size(), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
